vx_fpu_fma_arb: RTL and testbench

//  Shares one FMA pipeline (DSP/DPI FMA with pe serializer, fixed LATENCY_FMA) among
//  NUM_REQS issue sources. Round-robin arbitration with per-source credit limits.

---
 rtl/vx_fpu_fma_arb.sv | 184 ++++++++++++++++++
 tb/tb_vx_fpu_fma_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_fma_arb.sv
// Round-robin arbiter sharing one FMA pipeline among NUM_REQS issue sources.
// Each source is limited to MAX_CREDITS outstanding operations. Requests pass
// through a one-entry registered stage. The source index travels in the upper
// bits of the FMA tag, and responses are steered back to their source by it.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. While valid is high and ready is low,
// the sender holds valid, data and tag stable. The response channel is purely
// combinational from the FMA to the sources.
module vx_fpu_fma_arb #(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 112,
  parameter int RSP_DATAW   = 37,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_CREDITS = 4,
  localparam int IDXW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int FTAGW      = IDXW + TAG_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*DATAW-1:0]     req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          fma_valid,
  output logic [DATAW-1:0]              fma_data,
  output logic [FTAGW-1:0]              fma_tag,
  input  logic                          fma_ready,
  input  logic                          fma_rsp_valid,
  input  logic [RSP_DATAW-1:0]          fma_rsp_data,
  input  logic [FTAGW-1:0]              fma_rsp_tag,
  output logic                          fma_rsp_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [RSP_DATAW-1:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_CREDITS + 1);

  logic [CW-1:0]       credit_q [NUM_REQS];
  logic [CW-1:0]       credit_d [NUM_REQS];
  logic [IDXW-1:0]     rr_q, rr_d;
  logic                stage_valid_q, stage_valid_d;
  logic [DATAW-1:0]    stage_data_q, stage_data_d;
  logic [FTAGW-1:0]    stage_tag_q, stage_tag_d;

  logic [NUM_REQS-1:0] eligible;
  logic                grant_found;
  logic [IDXW-1:0]     grant_idx;
  logic                can_load;
  logic                grant_fire;
  logic [IDXW-1:0]     rsp_src;
  logic                rsp_src_ok;
  logic                rsp_fire;
  logic                any_credit;

  // A source may compete only while it has credit left.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (credit_q[i] < CW'(MAX_CREDITS));
    end
  end

  // Round-robin pick: the first eligible index at or after rr_q, wrapping.
  // The loop runs from the farthest offset to the nearest one, so the
  // nearest eligible source is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      logic [IDXW-1:0] idx_v;
      idx_v = IDXW'((int'(rr_q) + k) % NUM_REQS);
      if (eligible[idx_v]) begin
        grant_found = 1'b1;
        grant_idx   = idx_v;
      end
    end
  end

  assign can_load   = !stage_valid_q || fma_ready;
  assign grant_fire = grant_found && can_load && !reset;

  // At most one req_ready is high, and only when the stage can take a request.
  always_comb begin
    req_ready = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  // The response source index is held in the top IDXW bits of the FMA tag.
  assign rsp_src    = (NUM_REQS > 1) ? fma_rsp_tag[FTAGW-1 -: IDXW] : '0;
  assign rsp_src_ok = int'(rsp_src) < NUM_REQS;

  // Steer the response to its source, and return that source's ready to the FMA.
  always_comb begin
    rsp_valid     = '0;
    fma_rsp_ready = 1'b0;
    if (!reset && rsp_src_ok) begin
      rsp_valid[rsp_src] = fma_rsp_valid;
      fma_rsp_ready      = rsp_ready[rsp_src];
    end
  end

  assign rsp_fire = fma_rsp_valid && fma_rsp_ready;
  assign rsp_data = fma_rsp_data;
  assign rsp_tag  = fma_rsp_tag[TAG_WIDTH-1:0];

  // Credit update. A grant and a response on the same source in the same
  // cycle cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      logic inc, dec;
      inc = grant_fire && (grant_idx == IDXW'(i));
      dec = rsp_fire && (rsp_src == IDXW'(i));
      credit_d[i] = credit_q[i];
      if (inc && !dec)      credit_d[i] = credit_q[i] + CW'(1);
      else if (dec && !inc) credit_d[i] = credit_q[i] - CW'(1);
    end
  end

  // After a grant, the pointer advances to the index just past the winner.
  always_comb begin
    rr_d = rr_q;
    if (grant_fire) begin
      if (int'(grant_idx) == NUM_REQS - 1) rr_d = '0;
      else                                 rr_d = grant_idx + IDXW'(1);
    end
  end

  // Output stage. It loads on a grant, empties when the FMA takes the entry
  // and nothing new is granted, and otherwise holds its contents.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    stage_tag_d   = stage_tag_q;
    if (grant_fire) begin
      stage_valid_d = 1'b1;
      stage_data_d  = req_data[int'(grant_idx)*DATAW +: DATAW];
      stage_tag_d   = {grant_idx, req_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH]};
    end else if (fma_ready) begin
      stage_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_tag_q   <= '0;
      rr_q          <= '0;
      for (int i = 0; i < NUM_REQS; i++) credit_q[i] <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_tag_q   <= stage_tag_d;
      rr_q          <= rr_d;
      for (int i = 0; i < NUM_REQS; i++) credit_q[i] <= credit_d[i];
    end
  end

  // Busy while any credit is outstanding or the stage holds a request.
  always_comb begin
    any_credit = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (credit_q[i] != '0) any_credit = 1'b1;
    end
  end

  assign fma_valid = stage_valid_q;
  assign fma_data  = stage_data_q;
  assign fma_tag   = stage_tag_q;
  assign busy      = stage_valid_q || any_credit;

  // A response must belong to a source that has an operation outstanding.
  always @(posedge clk) begin
    if (!reset && rsp_fire) begin
      assert (credit_q[rsp_src] != '0);
    end
  end

endmodule

// File: tb/tb_vx_fpu_fma_arb.sv
// Testbench for vx_fpu_fma_arb. Directed scenarios and a random phase are
// checked against a transaction-level model of the arbiter. The bench also
// plays the role of the FMA and returns accepted operations in order.
module tb_vx_fpu_fma_arb;
  localparam int NR = 4, DW = 112, RW = 37, TW = 8, FTW = 10;

  logic              clk = 0, reset = 1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR*TW-1:0]  req_tag = '0;
  logic [NR-1:0]     req_ready;
  logic              fma_valid;
  logic [DW-1:0]     fma_data;
  logic [FTW-1:0]    fma_tag;
  logic              fma_ready = 0;
  logic              fma_rsp_valid = 0;
  logic [RW-1:0]     fma_rsp_data = '0;
  logic [FTW-1:0]    fma_rsp_tag = '0;
  logic              fma_rsp_ready;
  logic [NR-1:0]     rsp_valid;
  logic [RW-1:0]     rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic [NR-1:0]     rsp_ready = '0;
  logic              busy;

  vx_fpu_fma_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .fma_valid(fma_valid),
    .fma_data(fma_data), .fma_tag(fma_tag), .fma_ready(fma_ready),
    .fma_rsp_valid(fma_rsp_valid), .fma_rsp_data(fma_rsp_data),
    .fma_rsp_tag(fma_rsp_tag), .fma_rsp_ready(fma_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_total = 0, n_pass = 0;

  // Reference model state: outstanding ops per source, arbitration pointer,
  // contents of the output stage, and the ops the FMA has accepted (exp_q).
  int             m_cred [NR];
  int             m_ptr;
  bit             m_sv;
  logic [DW-1:0]  m_sd;
  logic [FTW-1:0] m_st;
  logic [FTW-1:0] exp_q[$];

  // Observations and expectations for the last cycle.
  int             last_g;
  bit             last_rsp_fire;
  logic [NR-1:0]  obs_rr, exp_rr, obs_rv, exp_rv;
  logic           obs_frr, exp_frr;
  logic [TW-1:0]  obs_rtag;
  logic [RW-1:0]  obs_rdata;

  function automatic bit m_busy();
    int s = 0;
    for (int i = 0; i < NR; i++) s += m_cred[i];
    return m_sv || (s > 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cred[i] = 0;
    m_ptr = 0; m_sv = 0; exp_q.delete();
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      req_tag[i*TW +: TW]  = TW'($urandom());
    end
  endtask

  // Present the oldest outstanding FMA op as the response, if one exists.
  task automatic drive_rsp(input bit en);
    fma_rsp_valid = en && (exp_q.size() > 0);
    if (exp_q.size() > 0) fma_rsp_tag = exp_q[0];
    fma_rsp_data = RW'({$urandom(), $urandom()});
  endtask

  // One clock cycle. Inputs are already driven. Sample the combinational
  // outputs, take the edge, then advance the model.
  task automatic cycle();
    int s;
    #1;
    obs_rr = req_ready; obs_rv = rsp_valid; obs_frr = fma_rsp_ready;
    obs_rtag = rsp_tag; obs_rdata = rsp_data;
    last_g = -1;
    if (!m_sv || fma_ready) begin
      for (int k = NR - 1; k >= 0; k--) begin
        int idx = (m_ptr + k) % NR;
        if (req_valid[idx] && m_cred[idx] < 4) last_g = idx;
      end
    end
    exp_rr = (last_g >= 0) ? (4'b0001 << last_g) : 4'b0000;
    s = int'(fma_rsp_tag[FTW-1 -: 2]);
    exp_rv  = fma_rsp_valid ? (4'b0001 << s) : 4'b0000;
    exp_frr = rsp_ready[s];
    @(posedge clk);
    if (m_sv && fma_ready) exp_q.push_back(m_st);
    last_rsp_fire = fma_rsp_valid && rsp_ready[s];
    if (last_rsp_fire) begin
      void'(exp_q.pop_front());
      m_cred[s]--;
    end
    if (last_g >= 0) begin
      logic [1:0] gi;
      gi = 2'(last_g);
      m_sv = 1;
      m_sd = req_data[last_g*DW +: DW];
      m_st = {gi, req_tag[last_g*TW +: TW]};
      m_ptr = (last_g + 1) % NR;
      m_cred[last_g]++;
    end else if (fma_ready) begin
      m_sv = 0;
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    req_valid = '0; fma_ready = 1; rsp_ready = '1;
    while ((m_sv || exp_q.size() > 0) && guard < 100) begin
      drive_rsp(1);
      cycle();
      guard++;
    end
    fma_rsp_valid = 0;
    n_total++;
    if (guard >= 100 || busy !== 1'b0)
      $display("FAIL drain: busy=%b guard=%0d, required busy=0 within 100 cycles", busy, guard);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = '1; fma_ready = 1; rsp_ready = '1;
    fma_rsp_valid = 1; fma_rsp_tag = {2'd1, 8'h55};
    @(posedge clk); #1;
    n_total++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b exp 0000", req_ready); else n_pass++;
    n_total++; if (fma_rsp_ready !== 1'b0) $display("FAIL reset_fma_rsp_ready: got %b exp 0", fma_rsp_ready); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); else n_pass++;
    n_total++; if (fma_valid !== 1'b0) $display("FAIL reset_fma_valid: got %b exp 0", fma_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    @(posedge clk); #1;
    reset = 0; req_valid = '0; fma_rsp_valid = 0; rsp_ready = '0; fma_rsp_tag = '0;
    model_reset();
  endtask

  task automatic test_round_robin();
    rand_reqs(); req_valid = '1; fma_ready = 1; fma_rsp_valid = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_total++; if (last_g != c % NR || obs_rr !== (4'b0001 << (c % NR)))
        $display("FAIL rr_grant[%0d]: got req_ready=%b exp source %0d", c, obs_rr, c % NR); else n_pass++;
      n_total++; if (fma_tag !== {2'(c % NR), req_tag[(c % NR)*TW +: TW]} || fma_data !== req_data[(c % NR)*DW +: DW])
        $display("FAIL rr_stage[%0d]: got tag=%h exp %h", c, fma_tag, {2'(c % NR), req_tag[(c % NR)*TW +: TW]}); else n_pass++;
    end
    drain();
  endtask

  task automatic test_stall();
    logic [DW-1:0] d0; logic [FTW-1:0] t0;
    rand_reqs(); req_valid = '1; fma_ready = 0;
    cycle();
    d0 = fma_data; t0 = fma_tag;
    n_total++; if (fma_valid !== 1'b1 || t0 !== m_st) $display("FAIL stall_load: got valid=%b tag=%h exp 1 %h", fma_valid, t0, m_st); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      rand_reqs();
      cycle();
      n_total++; if (obs_rr !== 4'b0) $display("FAIL stall_req_ready[%0d]: got %b exp 0000", c, obs_rr); else n_pass++;
      n_total++; if (fma_data !== d0 || fma_tag !== t0 || fma_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got tag=%h exp %h", c, fma_tag, t0); else n_pass++;
    end
    drain();
  endtask

  task automatic test_credit_limit();
    rand_reqs(); req_valid = 4'b0010; fma_ready = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_total++; if (obs_rr !== 4'b0010) $display("FAIL credit_grant[%0d]: got %b exp 0010", c, obs_rr); else n_pass++;
    end
    cycle();
    n_total++; if (obs_rr !== 4'b0000) $display("FAIL credit_block: got %b exp 0000", obs_rr); else n_pass++;
    req_valid = 4'b0110;
    cycle();
    n_total++; if (obs_rr !== 4'b0100) $display("FAIL credit_other: got %b exp 0100", obs_rr); else n_pass++;
    req_valid = 4'b0010; rsp_ready = '1; drive_rsp(1);
    cycle();
    n_total++; if (!last_rsp_fire || obs_rr !== 4'b0000) $display("FAIL credit_return: got req_ready=%b fire=%0d exp 0000 1", obs_rr, last_rsp_fire); else n_pass++;
    fma_rsp_valid = 0;
    cycle();
    n_total++; if (obs_rr !== 4'b0010) $display("FAIL credit_regrant: got %b exp 0010", obs_rr); else n_pass++;
    drain();
  endtask

  task automatic test_rsp_backpressure();
    rand_reqs(); req_valid = 4'b0100; fma_ready = 1;
    cycle();
    req_valid = '0;
    cycle();
    rsp_ready = 4'b1011; drive_rsp(1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_total++; if (obs_rv !== 4'b0100 || obs_frr !== 1'b0)
        $display("FAIL bp_hold[%0d]: got rsp_valid=%b fma_rsp_ready=%b exp 0100 0", c, obs_rv, obs_frr); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d]: got %b exp 1", c, busy); else n_pass++;
    end
    rsp_ready = '1;
    cycle();
    n_total++; if (obs_frr !== 1'b1 || obs_rtag !== fma_rsp_tag[TW-1:0] || obs_rdata !== fma_rsp_data)
      $display("FAIL bp_fire: got ready=%b tag=%h exp 1 %h", obs_frr, obs_rtag, fma_rsp_tag[TW-1:0]); else n_pass++;
    fma_rsp_valid = 0;
    n_total++; if (busy !== 1'b0) $display("FAIL bp_release: got busy=%b exp 0", busy); else n_pass++;
  endtask

  task automatic test_same_cycle();
    rand_reqs(); req_valid = 4'b0001; fma_ready = 1; fma_rsp_valid = 0;
    cycle(); cycle();
    req_valid = '0;
    cycle();
    n_total++; if (dut.credit_q[0] !== 3'd2) $display("FAIL same_pre_credit: got %0d exp 2", dut.credit_q[0]); else n_pass++;
    req_valid = 4'b0001; rsp_ready = '1; drive_rsp(1);
    cycle();
    n_total++; if (last_g != 0 || !last_rsp_fire || obs_rr !== 4'b0001)
      $display("FAIL same_events: got req_ready=%b fire=%0d exp 0001 1", obs_rr, last_rsp_fire); else n_pass++;
    n_total++; if (dut.credit_q[0] !== 3'd2) $display("FAIL same_credit: got %0d exp 2", dut.credit_q[0]); else n_pass++;
    fma_rsp_valid = 0;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_reqs();
      req_valid = NR'($urandom());
      fma_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = NR'($urandom());
      drive_rsp($urandom_range(0, 1) == 1);
      cycle();
      n_total++; if (obs_rr !== exp_rr) $display("FAIL rnd_req_ready[%0d]: got %b exp %b", c, obs_rr, exp_rr); else n_pass++;
      n_total++; if (obs_rv !== exp_rv || obs_frr !== exp_frr)
        $display("FAIL rnd_rsp[%0d]: got %b/%b exp %b/%b", c, obs_rv, obs_frr, exp_rv, exp_frr); else n_pass++;
      n_total++; if (fma_valid !== m_sv || (m_sv && (fma_data !== m_sd || fma_tag !== m_st)))
        $display("FAIL rnd_stage[%0d]: got valid=%b tag=%h exp %b %h", c, fma_valid, fma_tag, m_sv, m_st); else n_pass++;
      n_total++; if (busy !== m_busy()) $display("FAIL rnd_busy[%0d]: got %b exp %b", c, busy, m_busy()); else n_pass++;
    end
    drain();
  endtask

  task automatic test_reset_midop();
    rand_reqs(); req_valid = 4'b0111; fma_ready = 1; fma_rsp_valid = 0;
    cycle(); cycle(); cycle();
    reset = 1; req_valid = '0;
    @(posedge clk); #1;
    n_total++; if (fma_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midop_reset: got fma_valid=%b busy=%b exp 0 0", fma_valid, busy); else n_pass++;
    reset = 0; model_reset();
    req_valid = '1;
    cycle();
    n_total++; if (obs_rr !== 4'b0001) $display("FAIL midop_pointer: got %b exp 0001", obs_rr); else n_pass++;
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_credit_limit();
    test_rsp_backpressure();
    test_same_cycle();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
